// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_pkg
// Brief   : Shared widths, constants and fetch FSM type for the LEGv8 fetch
//           stage and the pipeline registers that reuse if_id_reg.
// Revision: 1.0  initial release
// ============================================================================
package if_stage_pkg;

  // Datapath widths (match the WORD / INST_SIZE widths used across the core)
  localparam int WORD_W = 64;
  localparam int INST_W = 32;

  // Fetch controller states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  // LEGv8 NOP encoding, used as the bubble instruction
  localparam logic [INST_W-1:0] NOP_INST = 32'hD503201F;

  // Sequential fetch stride in bytes
  localparam logic [WORD_W-1:0] PC_INCR = 64'd4;

  // A fetch address is illegal when it is not word aligned or lies past the
  // end of instruction memory.
  function automatic logic pc_fault(input logic [WORD_W-1:0] pc,
                                    input logic [WORD_W-1:0] limit);
    return (pc[1:0] != 2'b00) || (pc >= limit);
  endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : Generic IF/ID-style pipeline register with hold and flush.
//           Flush beats hold; hold keeps every field; otherwise the inputs
//           are captured.
// Revision: 1.0  initial release
// ============================================================================
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              valid,
  output logic [WORD_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  // Pipeline register: reset/flush inserts a bubble, hold freezes contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (flush) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= NOP_INST;
    end else if (!hold) begin
      valid <= in_valid;
      pc    <= in_pc;
      inst  <= in_inst;
    end
  end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Brief   : LEGv8 instruction-fetch stage. Owns the PC, drives it to the
//           combinational instruction memory and captures the returned word
//           into IF/ID. Handles stalls, redirect+flush and traps on illegal
//           fetch addresses (misaligned or beyond instruction memory).
// Revision: 1.0  initial release
// ============================================================================
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 64'd0,
  parameter int                IMEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  output logic              if_id_valid,
  output logic [WORD_W-1:0] if_id_pc,
  output logic [INST_W-1:0] if_id_inst,
  output logic              fetch_err
);

  localparam logic [WORD_W-1:0] IMEM_LIMIT = WORD_W'(IMEM_BYTES);

  fetch_state_t      state;
  logic [WORD_W-1:0] pc;
  logic              fault;
  logic              reg_hold;
  logic              reg_flush;

  // Faults are judged on the PC currently held, so a bad redirect target is
  // loaded first and trapped on the following edge without ever being fetched.
  assign fault   = pc_fault(pc, IMEM_LIMIT);
  assign imem_pc = pc;

  // IF/ID control: only RUN moves the register; a fault or redirect flushes it.
  // BOOT and TRAP hold the bubble that reset or the fault flush left behind.
  always_comb begin
    reg_hold  = 1'b1;
    reg_flush = 1'b0;
    if (state == RUN) begin
      if (fault || redirect) begin
        reg_flush = 1'b1;
      end else if (!stall) begin
        reg_hold = 1'b0;
      end
    end
  end

  // PC and fetch controller: priority fault > redirect > stall > sequential
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (fault) begin
            // pc keeps the faulting value for debug
            state     <= TRAP;
            fetch_err <= 1'b1;
          end else if (redirect) begin
            pc <= redirect_pc;
          end else if (!stall) begin
            pc <= pc + PC_INCR;
          end
        end
        TRAP: begin
          fetch_err <= 1'b1;
        end
        default: begin
          // Unreachable encoding: park safely in the trap state
          state     <= TRAP;
          fetch_err <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (reg_hold),
    .flush    (reg_flush),
    .in_valid (1'b1),
    .in_pc    (pc),
    .in_inst  (imem_inst),
    .valid    (if_id_valid),
    .pc       (if_id_pc),
    .inst     (if_id_inst)
  );

endmodule : if_stage
`default_nettype wire
